cache_policy_requester: RTL
===========================

Name: cache_policy_requester

Overview:
- Initiator side of the cache replacement-policy interface. Accepts one classified cache access at a time from the tag-lookup stage.
- Hit: issues a one-cycle hit pulse so the policy can update its state. Miss: issues a one-cycle miss pulse, waits for the policy's done, captures the replacement block address and hands it to the refill engine over a valid/ready handshake.
- Sits between tag compare and the policy controller; single outstanding transaction.

Parameters:
- BW_ACCESS_ADDR, 32, width of the requested memory (access) address.
- N_CAPACITY_BLOCKS, 256, cache capacity in blocks (power of two, at least 2).
- N_WORDS_PER_BLOCK, 4, words per block; carried for interface consistency, no internal use.
- ASSOCIATIVITY, 1, cache associativity; carried for interface consistency, no internal use.
- BW_CAPACITY_BLOCKS, derived as CLOG2(N_CAPACITY_BLOCKS): width of cache block addresses.

Ports:
- clock_i  in  1  single clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  access request valid.
- req_ready_o  out  1  requester can accept a request.
- req_addr_i  in  BW_ACCESS_ADDR  access address.
- req_hit_i  in  1  1 = tag hit, 0 = miss.
- req_cache_addr_i  in  BW_CAPACITY_BLOCKS  block that hit; don't-care on miss.
- policy_access_addr_o  out  BW_ACCESS_ADDR  latched access address to the policy.
- policy_cache_addr_o  out  BW_CAPACITY_BLOCKS  latched hit block to the policy.
- policy_hit_o  out  1  one-cycle hit pulse.
- policy_miss_o  out  1  one-cycle miss pulse.
- policy_done_i  in  1  replacement address valid.
- policy_addr_i  in  BW_CAPACITY_BLOCKS  replacement block address.
- rpl_valid_o  out  1  replacement result valid to the refill engine.
- rpl_ready_i  in  1  refill engine accepts the result.
- rpl_addr_o  out  BW_CAPACITY_BLOCKS  block to replace.
- rpl_access_addr_o  out  BW_ACCESS_ADDR  access address that missed.
- busy_o  out  1  state is not IDLE.

Behaviour:
- FSM states: IDLE, HIT, MISS, WAIT, RESP.
- Reset: while reset_i=1 at a rising edge, state goes to IDLE and every registered output clears to 0, including address outputs and pulses. req_ready_o = (state==IDLE) && !reset_i, so it is 0 during reset.
- IDLE: req_ready_o=1. On req_valid_i && req_ready_o:
  - latch req_addr_i into policy_access_addr_o and rpl_access_addr_o;
  - latch req_cache_addr_i into policy_cache_addr_o;
  - go to HIT if req_hit_i=1, otherwise MISS.
- HIT: policy_hit_o=1 for exactly this cycle, then IDLE. If the request was accepted at cycle T, the pulse is at T+1 and the next request can be accepted at T+2.
- MISS: policy_miss_o=1 for exactly this cycle (T+1); policy_done_i is ignored here. Next state is WAIT.
- WAIT: on the first cycle with policy_done_i=1, capture policy_addr_i into rpl_addr_o and go to RESP. The policy must deassert done by the cycle after the miss pulse; stale done is its responsibility. There is no timeout; WAIT holds indefinitely.
- RESP: rpl_valid_o=1 and rpl_addr_o / rpl_access_addr_o are held stable until rpl_ready_i=1. On handshake, go to IDLE; rpl_valid_o=0 in the next cycle. If rpl_ready_i is already 1 on the first RESP cycle, RESP lasts one cycle.
- Miss latency: done at cycle D gives rpl_valid_o at D+1.
- policy_hit_o and policy_miss_o are never high in the same cycle, and never high outside HIT/MISS.
- Request inputs are ignored outside IDLE. The latched addresses hold their values until the next accepted request.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: CACHE_POLICY_REQUESTER_STATS_EN.
- Defined:
  - adds ports hit_count_o and miss_count_o, each out, 32 bits;
  - each counter increments by 1 on every policy_hit_o or policy_miss_o pulse respectively;
  - both saturate at 0xFFFFFFFF and clear on reset.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: assert reset_i 3 cycles -> all outputs 0, req_ready_o=0; first cycle after release -> req_ready_o=1, busy_o=0.
- Hit: req_addr_i=0x00001040, req_hit_i=1, req_cache_addr_i=0x2A accepted at T -> policy_hit_o=1 only at T+1 with policy_cache_addr_o=0x2A and policy_access_addr_o=0x00001040; req_ready_o=1 at T+2; policy_miss_o stays 0.
- Miss with delayed done: req_addr_i=0x0000ABC0, req_hit_i=0 at T -> policy_miss_o=1 at T+1; done_i=1 with policy_addr_i=0x07 at T+5 -> rpl_valid_o=1 at T+6 with rpl_addr_o=0x07 and rpl_access_addr_o=0x0000ABC0.
- Back-pressure: in RESP hold rpl_ready_i=0 for 4 cycles while req_valid_i=1 -> rpl_valid_o and rpl outputs stable, req_ready_o=0; release rpl_ready_i -> IDLE next cycle, new request accepted.
- Reset mid-operation: assert reset_i during WAIT -> next cycle IDLE, rpl_valid_o=0; a later policy_done_i=1 causes no rpl_valid_o.
- Stats (macro defined): 3 hits then 2 misses -> hit_count_o=3, miss_count_o=2; preload a counter near saturation -> holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/cache_policy_requester.sv
// Initiator side of the cache replacement-policy interface: hit/miss pulses to the policy, replacement result to refill.
// Optional access statistics (hit_count_o / miss_count_o) are enabled by defining CACHE_POLICY_REQUESTER_STATS_EN.
module cache_policy_requester #(
  parameter int BW_ACCESS_ADDR     = 32,
  parameter int N_CAPACITY_BLOCKS  = 256,
  parameter int N_WORDS_PER_BLOCK  = 4,
  parameter int ASSOCIATIVITY      = 1,
  parameter int BW_CAPACITY_BLOCKS = $clog2(N_CAPACITY_BLOCKS)
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [BW_ACCESS_ADDR-1:0]     req_addr_i,
  input  logic                          req_hit_i,
  input  logic [BW_CAPACITY_BLOCKS-1:0] req_cache_addr_i,
  output logic [BW_ACCESS_ADDR-1:0]     policy_access_addr_o,
  output logic [BW_CAPACITY_BLOCKS-1:0] policy_cache_addr_o,
  output logic                          policy_hit_o,
  output logic                          policy_miss_o,
  input  logic                          policy_done_i,
  input  logic [BW_CAPACITY_BLOCKS-1:0] policy_addr_i,
  output logic                          rpl_valid_o,
  input  logic                          rpl_ready_i,
  output logic [BW_CAPACITY_BLOCKS-1:0] rpl_addr_o,
  output logic [BW_ACCESS_ADDR-1:0]     rpl_access_addr_o,
  output logic                          busy_o
`ifdef CACHE_POLICY_REQUESTER_STATS_EN
  ,
  output logic [31:0]                   hit_count_o,
  output logic [31:0]                   miss_count_o
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HIT  = 3'd1,
    MISS = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  // Block/word geometry is fixed by the surrounding cache; unsupported setups land in this marker block.
  if (N_CAPACITY_BLOCKS < 2 || N_WORDS_PER_BLOCK < 1 || ASSOCIATIVITY < 1) begin : g_bad_config
  end

  state_t                          state_q;
  state_t                          state_d;
  logic                            accept;
  logic [BW_ACCESS_ADDR-1:0]       access_addr_q;
  logic [BW_CAPACITY_BLOCKS-1:0]   cache_addr_q;
  logic [BW_CAPACITY_BLOCKS-1:0]   rpl_addr_q;

  assign req_ready_o = (state_q == IDLE) && !reset_i;
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = req_hit_i ? HIT : MISS;
      HIT:     state_d = IDLE;
      MISS:    state_d = WAIT;
      WAIT:    if (policy_done_i) state_d = RESP;
      RESP:    if (rpl_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses are only loaded on acceptance / done, so they stay stable through RESP back-pressure.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      access_addr_q <= '0;
      cache_addr_q  <= '0;
      rpl_addr_q    <= '0;
    end else begin
      if (accept) begin
        access_addr_q <= req_addr_i;
        cache_addr_q  <= req_cache_addr_i;
      end
      if (state_q == WAIT && policy_done_i) begin
        rpl_addr_q <= policy_addr_i;
      end
    end
  end

  assign policy_access_addr_o = access_addr_q;
  assign rpl_access_addr_o    = access_addr_q;
  assign policy_cache_addr_o  = cache_addr_q;
  assign rpl_addr_o           = rpl_addr_q;
  assign policy_hit_o         = (state_q == HIT);
  assign policy_miss_o        = (state_q == MISS);
  assign rpl_valid_o          = (state_q == RESP);
  assign busy_o               = (state_q != IDLE);

`ifdef CACHE_POLICY_REQUESTER_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (policy_hit_o)  hit_cnt_q  <= sat_inc(hit_cnt_q);
      if (policy_miss_o) miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule
